// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the Smith-Waterman array sequencer.
//   BASE_A/C/G/T    - 2-bit nucleotide encoding used on read/reference buses
//   SW_SCORE_W      - default width of the V/F score buses
//   sw_ctrl_state_t - sequencer FSM states
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int SW_SCORE_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sw_ctrl_state_t;

endpackage

// File: rtl/sw_array_ctrl_if.sv
// sw_array_ctrl_if: bundles the host job/stream handshakes, the PE-array
// drive/return signals and the result outputs of sw_array_ctrl.
//   slave  modport - the sequencer (drives busy/done/ready/arr_*/results)
//   master modport - the environment (host sources and the PE array)
// Optional macro SW_CTRL_CYCLE_CNT_EN adds the 32-bit cycle_cnt result.
interface sw_array_ctrl_if #(
  parameter int SCORE_W = 10,
  parameter int POS_W   = 16
);

  logic               start;
  logic               busy;
  logic               done;
  logic [1:0]         read_base;
  logic               read_valid;
  logic               read_ready;
  logic [1:0]         ref_base;
  logic               ref_valid;
  logic               ref_last;
  logic               ref_ready;
  logic               arr_en;
  logic [1:0]         arr_s;
  logic               arr_store_s;
  logic [1:0]         arr_t;
  logic               arr_init;
  logic [SCORE_W-1:0] arr_v;
  logic [SCORE_W-1:0] arr_f;
  logic [SCORE_W-1:0] arr_v_last;
  logic               arr_init_last;
  logic [SCORE_W-1:0] best_score;
  logic [POS_W-1:0]   best_pos;
  logic               result_valid;
`ifdef SW_CTRL_CYCLE_CNT_EN
  logic [31:0]        cycle_cnt;
`endif

  modport slave (
`ifdef SW_CTRL_CYCLE_CNT_EN
    output cycle_cnt,
`endif
    input  start, read_base, read_valid, ref_base, ref_valid, ref_last,
    input  arr_v_last, arr_init_last,
    output busy, done, read_ready, ref_ready,
    output arr_en, arr_s, arr_store_s, arr_t, arr_init, arr_v, arr_f,
    output best_score, best_pos, result_valid
  );

  modport master (
`ifdef SW_CTRL_CYCLE_CNT_EN
    input  cycle_cnt,
`endif
    output start, read_base, read_valid, ref_base, ref_valid, ref_last,
    output arr_v_last, arr_init_last,
    input  busy, done, read_ready, ref_ready,
    input  arr_en, arr_s, arr_store_s, arr_t, arr_init, arr_v, arr_f,
    input  best_score, best_pos, result_valid
  );

endinterface

// File: rtl/sw_max_tracker.sv
// sw_max_tracker: running maximum of the last-PE score stream.
//   clk, rst     - clock, asynchronous active-high reset
//   clear_i      - zero best score, best position and output index
//   sample_i     - a valid column score is present on score_i
//   score_i      - V_out of the last PE (unsigned)
//   best_score_o - largest score sampled since clear
//   best_pos_o   - output index at which best_score_o first appeared
//   out_cnt_o    - number of samples since clear (saturating)
module sw_max_tracker
  import sw_pkg::*;
#(
  parameter int SCORE_W = SW_SCORE_W,
  parameter int POS_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               sample_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [SCORE_W-1:0] best_score_o,
  output logic [POS_W-1:0]   best_pos_o,
  output logic [POS_W-1:0]   out_cnt_o
);

  logic [SCORE_W-1:0] best_q, best_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   cnt_q, cnt_d;

  // Next-state: strict compare keeps the earliest index on ties.
  always_comb begin
    best_d = best_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      best_d = '0;
      pos_d  = '0;
      cnt_d  = '0;
    end else if (sample_i) begin
      if (score_i > best_q) begin
        best_d = score_i;
        pos_d  = cnt_q;
      end else begin
        best_d = best_q;
      end
      if (cnt_q != {POS_W{1'b1}}) begin
        cnt_d = cnt_q + POS_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
      pos_q  <= '0;
      cnt_q  <= '0;
    end else begin
      best_q <= best_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
    end
  end

  assign best_score_o = best_q;
  assign best_pos_o   = pos_q;
  assign out_cnt_o    = cnt_q;

endmodule

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: sequencer for a linear chain of NUM_PE Smith-Waterman PEs.
// Loads a short read, streams a reference with ready/valid backpressure,
// drains the chain and reports the best last-PE score and its position.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - sw_array_ctrl_if.slave: start/busy/done, read and reference
//              streams, PE0 drive (arr_*), last-PE return, results
// Optional macro SW_CTRL_CYCLE_CNT_EN adds bus.cycle_cnt (start..done cycles).
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_PE  = 8,
  parameter int SCORE_W = SW_SCORE_W,
  parameter int POS_W   = 16,
  parameter int F_BOUND = 0
) (
  input logic            clk,
  input logic            rst,
  sw_array_ctrl_if.slave bus
);

  localparam int LD_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  sw_ctrl_state_t   state_q, state_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [POS_W-1:0] in_cnt_q, in_cnt_d;
  logic             busy_q, done_q, result_valid_q;

  logic             start_acc_s, finish_s, sample_s;
  logic             read_ready_s, ref_ready_s;
  logic             arr_en_s, arr_store_s_s, arr_init_s;
  logic [1:0]       arr_s_s, arr_t_s;
  logic [POS_W-1:0] out_cnt_s;

  // FSM next state and per-cycle array drive.
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    in_cnt_d      = in_cnt_q;
    start_acc_s   = 1'b0;
    read_ready_s  = 1'b0;
    ref_ready_s   = 1'b0;
    arr_en_s      = 1'b0;
    arr_s_s       = 2'b00;
    arr_store_s_s = 1'b0;
    arr_t_s       = 2'b00;
    arr_init_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          state_d     = ST_LOAD;
          ld_cnt_d    = '0;
          in_cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        read_ready_s = 1'b1;
        if (bus.read_valid) begin
          arr_en_s      = 1'b1;
          arr_store_s_s = 1'b1;
          arr_s_s       = bus.read_base;
          if (ld_cnt_q == LD_W'(NUM_PE - 1)) begin
            state_d  = ST_STREAM;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end else begin
          arr_en_s = 1'b0;
        end
      end
      ST_STREAM: begin
        ref_ready_s = 1'b1;
        // No handshake leaves arr_en low so the chain holds its columns.
        if (bus.ref_valid) begin
          arr_en_s   = 1'b1;
          arr_init_s = 1'b1;
          arr_t_s    = bus.ref_base;
          if (in_cnt_q != {POS_W{1'b1}}) begin
            in_cnt_d = in_cnt_q + POS_W'(1);
          end else begin
            in_cnt_d = in_cnt_q;
          end
          // Reaching the all-ones column count ends the stream like ref_last.
          if (bus.ref_last || (in_cnt_d == {POS_W{1'b1}})) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          arr_en_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        arr_en_s = 1'b1;
        if (out_cnt_s == in_cnt_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign finish_s = (state_q == ST_DRAIN) && (state_d == ST_DONE);

  // Last-PE output is a real column only while enabled; once every column
  // has been counted, further drain cycles are ignored.
  assign sample_s = arr_en_s && bus.arr_init_last &&
                    ((state_q == ST_STREAM) ||
                     ((state_q == ST_DRAIN) && (out_cnt_s != in_cnt_q)));

  // FSM state, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ld_cnt_q       <= '0;
      in_cnt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      in_cnt_q <= in_cnt_d;
      done_q   <= finish_s;
      if (start_acc_s) begin
        busy_q         <= 1'b1;
        result_valid_q <= 1'b0;
      end else if (finish_s) begin
        busy_q         <= 1'b0;
        result_valid_q <= 1'b1;
      end else begin
        busy_q         <= busy_q;
        result_valid_q <= result_valid_q;
      end
    end
  end

  sw_max_tracker #(
    .SCORE_W (SCORE_W),
    .POS_W   (POS_W)
  ) u_max_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_acc_s),
    .sample_i     (sample_s),
    .score_i      (bus.arr_v_last),
    .best_score_o (bus.best_score),
    .best_pos_o   (bus.best_pos),
    .out_cnt_o    (out_cnt_s)
  );

`ifdef SW_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // Job length: the start cycle counts as 1, then every cycle through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else if (start_acc_s) begin
      cyc_q <= 32'd1;
    end else if ((state_q != ST_IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end else begin
      cyc_q <= cyc_q;
    end
  end

  assign bus.cycle_cnt = cyc_q;
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;
  assign bus.read_ready   = read_ready_s;
  assign bus.ref_ready    = ref_ready_s;
  assign bus.arr_en       = arr_en_s;
  assign bus.arr_s        = arr_s_s;
  assign bus.arr_store_s  = arr_store_s_s;
  assign bus.arr_t        = arr_t_s;
  assign bus.arr_init     = arr_init_s;
  assign bus.arr_v        = '0;
  assign bus.arr_f        = SCORE_W'(F_BOUND);

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl with a behavioural PE-chain stand-in:
// each reference column carries an index down an NUM_PE-deep enabled delay
// line and emerges with a score taken from a per-column table.
module tb_sw_array_ctrl;
  import sw_pkg::*;

  localparam int NUM_PE  = 6;
  localparam int SCORE_W = 10;
  localparam int POS_W   = 16;
  localparam int F_BOUND = -2;
  localparam logic [SCORE_W-1:0] F_EXP = SCORE_W'(F_BOUND);

  logic clk = 1'b0;
  logic rst = 1'b0;

  sw_array_ctrl_if #(.SCORE_W(SCORE_W), .POS_W(POS_W)) bus ();

  sw_array_ctrl #(
    .NUM_PE (NUM_PE), .SCORE_W (SCORE_W), .POS_W (POS_W), .F_BOUND (F_BOUND)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // PE-chain stand-in
  logic               init_pipe [NUM_PE];
  int                 col_pipe  [NUM_PE];
  int                 col_abs = 0;
  logic [SCORE_W-1:0] score_tab [2048];

  assign bus.arr_init_last = init_pipe[NUM_PE-1];
  assign bus.arr_v_last    = score_tab[col_pipe[NUM_PE-1] % 2048];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) begin
        init_pipe[k] <= 1'b0;
        col_pipe[k]  <= 0;
      end
    end else if (bus.arr_en) begin
      init_pipe[0] <= bus.arr_init;
      col_pipe[0]  <= col_abs;
      for (int k = 1; k < NUM_PE; k++) begin
        init_pipe[k] <= init_pipe[k-1];
        col_pipe[k]  <= col_pipe[k-1];
      end
      if (bus.arr_init) col_abs <= col_abs + 1;
    end
  end

  // Cycle counter and protocol monitor (mid-cycle observation)
  int         cyc_now = 0;
  int         done_total = 0, sample_total = 0, viol_total = 0;
  logic [1:0] loaded_q[$];
  logic [1:0] streamed_q[$];

  always @(posedge clk) cyc_now <= cyc_now + 1;

  always @(negedge clk) begin
    if (bus.done) done_total++;
    if (bus.arr_en && bus.arr_init_last) sample_total++;
    if ((bus.ref_valid && bus.ref_ready) != (bus.arr_en && bus.arr_init)) viol_total++;
    if ((bus.read_valid && bus.read_ready) != (bus.arr_en && bus.arr_store_s)) viol_total++;
    if (bus.ref_ready && bus.read_ready) viol_total++;
    if (bus.arr_v !== '0 || bus.arr_f !== F_EXP) viol_total++;
    if (bus.arr_en && bus.arr_store_s) loaded_q.push_back(bus.arr_s);
    if (bus.arr_en && bus.arr_init) streamed_q.push_back(bus.arr_t);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Job description consumed by run_job
  logic [1:0] rd_arr [NUM_PE];
  logic [1:0] rf_q[$];
  int         sc_q[$];
  int         last_hs_cyc, last_done_cyc;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   bus.busy, 1'b0);
    check({tag, "_done"},   bus.done, 1'b0);
    check({tag, "_rvalid"}, bus.result_valid, 1'b0);
    check({tag, "_best"},   bus.best_score, '0);
    check({tag, "_pos"},    bus.best_pos, '0);
    check({tag, "_ready"},  {bus.read_ready, bus.ref_ready}, 2'b00);
    check({tag, "_arr"},    {bus.arr_en, bus.arr_store_s, bus.arr_init}, 3'b000);
    check({tag, "_arr_f"},  bus.arr_f, F_EXP);
  endtask

  // bmode: 0 always valid, 1 pattern 1,0,0, 2 random; abort_at >= 0 resets
  // the DUT just before that reference beat.
  task automatic run_job(input int n, input int bmode, input bit extra_start, input int abort_at);
    int ld_b, st_b, dn_b, sm_b, vi_b, cb, guard, k, s_cyc, d_cyc, ep, mism;
    bit hs, seen, found;
    logic [SCORE_W-1:0] eb;
    cb = col_abs;
    for (int j = 0; j < n; j++) score_tab[(cb + j) % 2048] = SCORE_W'(sc_q[j]);
    ld_b = loaded_q.size(); st_b = streamed_q.size();
    dn_b = done_total; sm_b = sample_total; vi_b = viol_total;
    @(posedge clk); #1; bus.start = 1'b1;
    @(negedge clk); s_cyc = cyc_now;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    check("start_busy", bus.busy, 1'b1);
    check("start_rvalid_clr", bus.result_valid, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < NUM_PE; i++) begin
      guard = 0;
      do begin
        bus.read_valid = (bmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.read_base  = rd_arr[i];
        @(negedge clk); hs = bus.read_valid && bus.read_ready;
        @(posedge clk); #1; guard++;
      end while (!hs && guard < 64);
      if (!hs) begin check("load_timeout", 1'b0, 1'b1); bus.read_valid = 1'b0; return; end
    end
    bus.read_valid = 1'b0;
    k = 0;
    for (int j = 0; j < n; j++) begin
      guard = 0;
      do begin
        if (abort_at == j) begin
          rst = 1'b1; bus.ref_valid = 1'b0; bus.ref_last = 1'b0; bus.start = 1'b0;
          @(negedge clk);
          check_reset_outputs("abort");
          @(posedge clk); #1; rst = 1'b0;
          repeat (NUM_PE + 4) @(negedge clk);
          check("abort_no_done", done_total - dn_b, 0);
          check("abort_idle", {bus.busy, bus.result_valid}, 2'b00);
          @(posedge clk); #1;
          return;
        end
        bus.ref_valid = (bmode == 1) ? (k % 3 == 0) :
                        (bmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
        k++;
        bus.ref_base = rf_q[j];
        bus.ref_last = (j == n - 1);
        bus.start    = extra_start && (j == n / 2);
        @(negedge clk); hs = bus.ref_valid && bus.ref_ready;
        if (hs) last_hs_cyc = cyc_now;
        @(posedge clk); #1; guard++;
      end while (!hs && guard < 64);
      if (!hs) begin check("stream_timeout", 1'b0, 1'b1); bus.ref_valid = 1'b0; return; end
    end
    bus.ref_valid = 1'b0; bus.ref_last = 1'b0; bus.start = 1'b0;
    seen = 1'b0; guard = 0; d_cyc = 0;
    while (!seen && guard < 400) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; d_cyc = cyc_now; end
      guard++;
    end
    check("done_seen", seen, 1'b1);
    if (!seen) return;
    last_done_cyc = d_cyc;
    // Reference result: largest score, first column holding it.
    eb = '0;
    foreach (sc_q[j]) if (j < n && SCORE_W'(sc_q[j]) > eb) eb = SCORE_W'(sc_q[j]);
    ep = 0; found = 1'b0;
    for (int j = 0; j < n; j++) if (!found && SCORE_W'(sc_q[j]) == eb) begin ep = j; found = 1'b1; end
    check("best_score", bus.best_score, eb);
    check("best_pos", bus.best_pos, POS_W'(ep));
    check("done_status", {bus.result_valid, bus.busy}, 2'b10);
    check("sample_count", sample_total - sm_b, n);
    mism = 0;
    if (loaded_q.size() - ld_b != NUM_PE) mism++;
    else for (int i = 0; i < NUM_PE; i++) if (loaded_q[ld_b + i] !== rd_arr[i]) mism++;
    check("load_order", mism, 0);
    mism = 0;
    if (streamed_q.size() - st_b != n) mism++;
    else for (int j = 0; j < n; j++) if (streamed_q[st_b + j] !== rf_q[j]) mism++;
    check("stream_order", mism, 0);
    check("protocol", viol_total - vi_b, 0);
    @(negedge clk);
    check("done_pulse", {bus.done, 32'(done_total - dn_b)}, {1'b0, 32'd1});
`ifdef SW_CTRL_CYCLE_CNT_EN
    check("cycle_cnt", bus.cycle_cnt, 32'(d_cyc - s_cyc + 1));
`endif
  endtask

  task automatic set_job(input int n);
    rf_q.delete(); sc_q.delete();
    for (int j = 0; j < n; j++) begin
      rf_q.push_back(2'($urandom_range(0, 3)));
      sc_q.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 1023));
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.read_valid = 1'b0; bus.read_base = 2'b00;
    bus.ref_valid = 1'b0; bus.ref_base = 2'b00; bus.ref_last = 1'b0;
    for (int i = 0; i < 2048; i++) score_tab[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    rd_arr = '{BASE_A, BASE_C, BASE_A, BASE_C, BASE_T, BASE_A};

    // Reset in the middle of a stream, then a normal job
    set_job(12);
    run_job(12, 0, 1'b0, NUM_PE + 3);
    rf_q = '{BASE_A, BASE_C, BASE_A, BASE_G, BASE_A, BASE_C, BASE_T, BASE_A};
    sc_q = '{8, 10, 20, 18, 5, 20, 3, 1};
    run_job(8, 0, 1'b0, -1);

    // Same job with ref_valid 1,0,0,... bubbles
    run_job(8, 1, 1'b0, -1);

    // Equal maxima at indices 2 and 5
    sc_q = '{3, 7, 12, 9, 1, 12, 4, 0};
    run_job(8, 0, 1'b0, -1);

    // Single-beat job; result holds until the next start
    rf_q = '{BASE_G};
    sc_q = '{17};
    run_job(1, 0, 1'b0, -1);
    check("single_latency", (last_done_cyc - last_hs_cyc) >= NUM_PE, 1'b1);
    repeat (5) @(negedge clk);
    check("rvalid_hold", {bus.result_valid, bus.best_score}, {1'b1, 10'd17});

    // start while busy is ignored
    rf_q = '{BASE_A, BASE_C, BASE_A, BASE_G, BASE_A, BASE_C, BASE_T, BASE_A};
    sc_q = '{8, 10, 20, 18, 5, 20, 3, 1};
    run_job(8, 0, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("no_restart", {bus.busy, bus.result_valid}, 2'b01);

    // All-zero scores keep position 0
    set_job(5);
    sc_q = '{0, 0, 0, 0, 0};
    run_job(5, 0, 1'b0, -1);

    // Randomized jobs with random read, length and backpressure
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_PE; i++) rd_arr[i] = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 20);
      set_job(n);
      run_job(n, 2, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
Sequencer for a linear chain of NUM_PE Smith-Waterman PEs with affine gap scoring.
- Loads one short read into the chain.
- Streams a reference of arbitrary length through it with ready/valid backpressure.
- Drains the pipeline and reports the best local-alignment score seen at the last PE, plus its reference position.
- Sits between the host-side read/reference stream sources and the PE array top.

Parameters:
NUM_PE, 8, number of PEs in the chain (= short read length)
SCORE_W, 10, width of V/F score buses
POS_W, 16, width of reference position counter
F_BOUND, 0, constant driven on chain F input (two's complement)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a job when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when job complete
read_base  in  2  short-read base (00 A, 01 C, 10 G, 11 T)
read_valid  in  1  read_base valid
read_ready  out  1  controller accepts read_base
ref_base  in  2  reference base
ref_valid  in  1  ref_base valid
ref_last  in  1  marks final reference base
ref_ready  out  1  controller accepts ref_base
arr_en  out  1  array clock enable; array holds state when low
arr_s  out  2  S input to PE0
arr_store_s  out  1  store_S input to PE0
arr_t  out  2  T input to PE0
arr_init  out  1  init input to PE0
arr_v  out  SCORE_W  V input to PE0; constant 0
arr_f  out  SCORE_W  F input to PE0; constant F_BOUND
arr_v_last  in  SCORE_W  V_out of PE NUM_PE-1
arr_init_last  in  1  init_out of PE NUM_PE-1
best_score  out  SCORE_W  maximum arr_v_last, unsigned
best_pos  out  POS_W  output index at which best_score first occurred
result_valid  out  1  high from done until next accepted start

Behaviour:
- Reset: all outputs 0 (arr_f = F_BOUND); FSM to IDLE. Reset mid-job aborts it; no done pulse is issued.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start accepted → LOAD; clears best_score, best_pos, in_cnt, out_cnt, result_valid.
  - start while busy is ignored.
- LOAD:
  - read_ready = 1.
  - Each read handshake drives, for that cycle: arr_s = read_base, arr_store_s = 1, arr_en = 1, arr_init = 0.
  - Bases go to the array in arrival order.
  - Without a handshake: arr_en = 0, arr_store_s = 0.
  - After NUM_PE handshakes → STREAM. ref_ready stays 0 during LOAD.
- STREAM:
  - ref_ready = 1.
  - Each ref handshake drives: arr_t = ref_base, arr_init = 1, arr_en = 1; in_cnt increments.
  - No handshake: arr_en = 0, which freezes the array, so a bubble never injects a fake column.
  - Handshake with ref_last → DRAIN.
- DRAIN:
  - ref_ready = 0; arr_en = 1 every cycle; arr_init = 0; arr_t = 0.
  - When out_cnt == in_cnt → DONE.
- Output capture (STREAM and DRAIN):
  - Sample when arr_en & arr_init_last.
  - If arr_v_last > best_score (strictly greater): best_score ← arr_v_last, best_pos ← out_cnt.
  - Ties keep the earliest position.
  - out_cnt increments on every sample.
  - First sample occurs NUM_PE enabled cycles after the first ref handshake.
- DONE: done = 1 for one cycle, result_valid ← 1, busy ← 0 → IDLE.
- Counters saturate at all-ones.
  - in_cnt saturation forces DRAIN as if ref_last had been seen.
  - best_pos is then meaningless; flagged by in_cnt saturated.
- Boundary: ref_last on the first ref beat is a legal single-column job.

Optional Feature:
SW_CTRL_CYCLE_CNT_EN:
- Defined: adds output cycle_cnt[31:0], counting clk cycles from accepted start to done inclusive. Frozen at done, cleared on next start, saturating.
- Undefined: port and counter are absent.

Decomposition:
- Package sw_pkg holds:
  - base encoding constants (BASE_A/C/G/T);
  - FSM state enum sw_ctrl_state_t;
  - SCORE_W default constant.
- One natural sub-module: sw_max_tracker.
  - Holds compare/capture of best_score/best_pos and out_cnt.
  - Inputs: sample strobe, score, clear.

Test Plan:
1. Reset asserted mid-STREAM → all outputs 0, busy 0, no done; a new start then completes normally.
2. Load read A,C,A,C,T,A (NUM_PE=6), stream ref A,C,A,G,A,C,T,A with ref_valid always high, arr_v_last model = 8,10,20,18,... → done after in_cnt = out_cnt = 8; best_score = max of model values, best_pos = its first index.
3. ref_valid toggled 1,0,0,1,... during STREAM → arr_en low on idle cycles, array state unchanged, identical results to scenario 2.
4. Equal maxima 12 at out indices 2 and 5 → best_pos = 2.
5. Single reference beat with ref_last → exactly one sample, done NUM_PE+ cycles later, result_valid holds until next start.
6. start pulsed while busy → ignored; with SW_CTRL_CYCLE_CNT_EN, cycle_cnt equals measured start-to-done cycles.
